// File: rtl/rotation_emulator.sv
// rotation_emulator: synthesizable stand-in for the spinning rotor and its IR break-beam sensor.
// Produces a ramped-period ir_tripped pulse train plus the ideal slice index (true_dtheta) of the
// revolution in progress, so the display pipeline can run without the motor.
// Optional build macro ROT_EMU_BOUNCE_EN: punches one-cycle low glitches into each pulse at
// cnt == 2 and cnt == 5 to emulate contact bounce (PULSE_W must then be at least 8).
module rotation_emulator #(
  parameter int unsigned PERIOD_W       = 27,
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned PULSE_W        = 16,
  parameter int unsigned START_PERIOD   = 2**26
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              enable_in,
  input  logic [PERIOD_W-1:0]               target_period_in,
  input  logic [PERIOD_W-1:0]               step_in,
  output logic                              ir_tripped,
  output logic [$clog2(ROTATIONAL_RES)-1:0] true_dtheta,
  output logic [PERIOD_W-1:0]               cur_period,
  output logic [15:0]                       rev_count,
  output logic                              locked
);

  localparam int unsigned         SliceW   = $clog2(ROTATIONAL_RES);
  localparam logic [PERIOD_W-1:0] ResP     = PERIOD_W'(ROTATIONAL_RES);
  localparam logic [PERIOD_W-1:0] StartP   = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] PulseP   = PERIOD_W'(PULSE_W);
  localparam logic [PERIOD_W-1:0] OneP     = PERIOD_W'(1);
  localparam logic [SliceW-1:0]   SliceMax = SliceW'(ROTATIONAL_RES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StSteady,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [15:0]         rev_q, rev_d;
  logic [PERIOD_W-1:0] sub_q, sub_d;
  logic [SliceW-1:0]   slice_q, slice_d;
  logic                ir_q, ir_d;

  logic [PERIOD_W-1:0] tgt;
  logic [PERIOD_W-1:0] cp;
  logic [PERIOD_W-1:0] ramp_next;
  logic [PERIOD_W-1:0] stop_next;
  logic                boundary;

  // Move cur toward goal by step without overshoot; step == 0 means jump. Each difference is
  // only formed once the ordering of its operands is known, so nothing can wrap.
  function automatic logic [PERIOD_W-1:0] step_toward(input logic [PERIOD_W-1:0] cur,
                                                      input logic [PERIOD_W-1:0] goal,
                                                      input logic [PERIOD_W-1:0] step);
    logic [PERIOD_W-1:0] res;
    res = goal;
    if (step != '0) begin
      if (cur < goal) begin
        if ((goal - cur) > step) res = cur + step;
      end else if (cur > goal) begin
        if ((cur - goal) > step) res = cur - step;
      end
    end
    return res;
  endfunction

  // Effective target, slice length and candidate next periods for the coming boundary.
  always_comb begin
    tgt       = (target_period_in < ResP) ? ResP : target_period_in;
    cp        = period_q >> SliceW;
    ramp_next = step_toward(period_q, tgt, step_in);
    stop_next = step_toward(period_q, StartP, step_in);
    boundary  = (state_q != StIdle) && (cnt_q == (period_q - OneP));
  end

  // Next-state logic: revolution/slice counters and the spin-control FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    rev_d    = rev_q;
    sub_d    = sub_q;
    slice_d  = slice_q;

    // Counters only run while the rotor is turning; they sit at zero in idle.
    if (state_q != StIdle) begin
      if (boundary) begin
        cnt_d   = '0;
        sub_d   = '0;
        slice_d = '0;
        rev_d   = rev_q + 16'd1;
      end else begin
        cnt_d = cnt_q + OneP;
        if (sub_q == (cp - OneP)) begin
          sub_d = '0;
          if (slice_q != SliceMax) slice_d = slice_q + 1'b1;
        end else begin
          sub_d = sub_q + OneP;
        end
      end
    end

    case (state_q)
      StIdle: begin
        if (enable_in) begin
          state_d  = StRamp;
          period_d = StartP;
          cnt_d    = '0;
          sub_d    = '0;
          slice_d  = '0;
        end
      end
      StRamp: begin
        if (boundary) begin
          if (!enable_in) begin
            state_d  = StStop;
            period_d = stop_next;
          end else begin
            period_d = ramp_next;
            if (ramp_next == tgt) state_d = StSteady;
          end
        end
      end
      StSteady: begin
        if (boundary) begin
          if (!enable_in) begin
            state_d  = StStop;
            period_d = stop_next;
          end else if (tgt != period_q) begin
            state_d = StRamp;
          end
        end
      end
      StStop: begin
        // The revolution run at the standstill period is the last one: idle is entered at the
        // boundary that completes it, so that final revolution is always emitted in full.
        if (boundary) begin
          if (enable_in) begin
            state_d = StRamp;
          end else if (period_q == StartP) begin
            state_d = StIdle;
          end else begin
            period_d = stop_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sensor pulse for the current counter position; registered below.
  always_comb begin
`ifdef ROT_EMU_BOUNCE_EN
    ir_d = (state_q != StIdle) && (cnt_q < PulseP) &&
           (cnt_q != PERIOD_W'(2)) && (cnt_q != PERIOD_W'(5));
`else
    ir_d = (state_q != StIdle) && (cnt_q < PulseP);
`endif
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= StartP;
      rev_q    <= '0;
      sub_q    <= '0;
      slice_q  <= '0;
      ir_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      rev_q    <= rev_d;
      sub_q    <= sub_d;
      slice_q  <= slice_d;
      ir_q     <= ir_d;
    end
  end

  assign ir_tripped  = ir_q;
  assign true_dtheta = slice_q;
  assign cur_period  = period_q;
  assign rev_count   = rev_q;
  assign locked      = (state_q == StSteady);

endmodule
